// File: rtl/usb_tx_data_encoder.sv
// Wraps payload beats into a USB DATAx packet: PID, payload, then CRC16 (low byte first).
// Output register is a single skid-free stage; upstream is paced by that register's availability.
module usb_tx_data_encoder #(
  parameter logic [7:0]  PID_DATA0 = 8'hC3,
  parameter logic [7:0]  PID_DATA1 = 8'h4B,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       parity_i,
  input  logic       s_tvalid,
  output logic       s_tready,
  input  logic       s_tkeep,
  input  logic       s_tlast,
  input  logic [7:0] s_tdata,
  output logic       m_tvalid,
  input  logic       m_tready,
  output logic       m_tlast,
  output logic [7:0] m_tdata,
  output logic       busy_o,
  output logic       sent_o
);

  typedef enum logic [2:0] {IDLE, PID, DATA, CRC0, CRC1} state_t;

  state_t      state_q, state_d;
  logic [15:0] crc_q, crc_d;
  logic        last_q, last_d;
  logic        m_tvalid_q, m_tvalid_d;
  logic        m_tlast_q, m_tlast_d;
  logic [7:0]  m_tdata_q, m_tdata_d;
  logic        sent_q, sent_d;

  logic        out_free;
  logic        beat_acc;
  logic [15:0] crc_tx;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {8'h00, data};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return c;
  endfunction

  assign out_free = !m_tvalid_q || m_tready;
  assign crc_tx   = ~crc_q;

  // Empty non-last beats in PID are discarded without waiting on the output register.
  always_comb begin
    s_tready = 1'b0;
    case (state_q)
      PID:     s_tready = (!s_tkeep && !s_tlast) || out_free;
      DATA:    s_tready = !last_q && out_free;
      default: s_tready = 1'b0;
    endcase
  end

  assign beat_acc = s_tvalid && s_tready;

  always_comb begin
    state_d    = state_q;
    crc_d      = crc_q;
    last_d     = last_q;
    m_tvalid_d = m_tvalid_q;
    m_tlast_d  = m_tlast_q;
    m_tdata_d  = m_tdata_q;
    sent_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (s_tvalid) begin
          crc_d      = CRC_INIT;
          last_d     = 1'b0;
          m_tvalid_d = 1'b1;
          m_tlast_d  = 1'b0;
          m_tdata_d  = parity_i ? PID_DATA1 : PID_DATA0;
          state_d    = PID;
        end
      end
      PID: begin
        if (out_free) begin
          m_tvalid_d = 1'b0;
          state_d    = DATA;
        end
        if (beat_acc && s_tkeep) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = s_tdata;
          crc_d      = crc16_byte(crc_q, s_tdata);
          last_d     = s_tlast;
        end else if (beat_acc && s_tlast) begin
          m_tvalid_d = 1'b1;
          m_tdata_d  = crc_tx[7:0];
          state_d    = CRC0;
        end
      end
      DATA: begin
        if (out_free) begin
          m_tvalid_d = 1'b0;
          if (last_q) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = crc_tx[7:0];
            last_d     = 1'b0;
            state_d    = CRC0;
          end else if (beat_acc) begin
            last_d = s_tlast;
            if (s_tkeep) begin
              m_tvalid_d = 1'b1;
              m_tdata_d  = s_tdata;
              crc_d      = crc16_byte(crc_q, s_tdata);
            end
          end
        end
      end
      CRC0: begin
        if (m_tready) begin
          m_tdata_d = crc_tx[15:8];
          m_tlast_d = 1'b1;
          state_d   = CRC1;
        end
      end
      CRC1: begin
        if (m_tready) begin
          m_tvalid_d = 1'b0;
          m_tlast_d  = 1'b0;
          sent_d     = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      crc_q      <= CRC_INIT;
      last_q     <= 1'b0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= 8'h00;
      sent_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      crc_q      <= crc_d;
      last_q     <= last_d;
      m_tvalid_q <= m_tvalid_d;
      m_tlast_q  <= m_tlast_d;
      m_tdata_q  <= m_tdata_d;
      sent_q     <= sent_d;
    end
  end

  assign m_tvalid = m_tvalid_q;
  assign m_tlast  = m_tlast_q;
  assign m_tdata  = m_tdata_q;
  assign sent_o   = sent_q;
  assign busy_o   = (state_q != IDLE);

endmodule

// File: tb/tb_usb_tx_data_encoder.sv
// Directed bench for usb_tx_data_encoder: packet byte streams, tlast placement, stalls, reset and gaps.
module tb_usb_tx_data_encoder;

  logic       clock = 1'b0;
  logic       reset;
  logic       parity_i;
  logic       s_tvalid, s_tready, s_tkeep, s_tlast;
  logic [7:0] s_tdata;
  logic       m_tvalid, m_tready, m_tlast;
  logic [7:0] m_tdata;
  logic       busy_o, sent_o;

  int vectors     = 0;
  int miscompares = 0;

  logic [7:0] bt_d [0:599];
  logic       bt_k [0:599];
  logic       bt_l [0:599];
  int         nbeats;
  logic [7:0] exp_d [0:599];
  int         n_exp;
  logic [7:0] obuf [0:599];
  logic       olast [0:599];
  int         nout, pid_cyc, last_cyc;
  logic       timeout;
  logic [15:0] crc_ref;

  always #5 clock = ~clock;

  usb_tx_data_encoder dut (
    .clock    (clock),
    .reset    (reset),
    .parity_i (parity_i),
    .s_tvalid (s_tvalid),
    .s_tready (s_tready),
    .s_tkeep  (s_tkeep),
    .s_tlast  (s_tlast),
    .s_tdata  (s_tdata),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tlast  (m_tlast),
    .m_tdata  (m_tdata),
    .busy_o   (busy_o),
    .sent_o   (sent_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    nbeats = 0;
    n_exp  = 0;
  endtask

  task automatic beat(input logic [7:0] d, input logic k, input logic l);
    bt_d[nbeats] = d;
    bt_k[nbeats] = k;
    bt_l[nbeats] = l;
    nbeats++;
  endtask

  task automatic expb(input logic [7:0] d);
    exp_d[n_exp] = d;
    n_exp++;
  endtask

  // Reference CRC16/USB over exp_d[first +: cnt], returned already inverted.
  function automatic logic [15:0] sw_crc(input int first, input int cnt);
    logic [15:0] c;
    c = 16'hFFFF;
    for (int i = first; i < first + cnt; i++) begin
      c = c ^ {8'h00, exp_d[i]};
      for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic load_std(input logic par);
    clr();
    expb(par ? 8'h4B : 8'hC3);
    for (int i = 0; i < 9; i++) begin
      beat(8'(8'h31 + i), 1'b1, i == 8);
      expb(8'(8'h31 + i));
    end
    expb(8'hC8);
    expb(8'hB4);
  endtask

  // Drives source and sink one cycle at a time; parity_i is flipped after the first cycle.
  task automatic run_pkt(input logic par, input int rmode, input int gap_at, input int abort_n);
    int bi = 0;
    int gap = 0;
    logic stall = 1'b0;
    logic [7:0] pdat = 8'h00;
    nout = 0; pid_cyc = -1; last_cyc = -1; timeout = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc > 0 && (sent_o || nout == abort_n)) begin
        timeout = 1'b0;
        break;
      end
      parity_i = (cyc == 0) ? par : ~par;
      if (bi < nbeats && !(bi == gap_at && gap < 3)) begin
        s_tvalid = 1'b1;
        s_tdata  = bt_d[bi];
        s_tkeep  = bt_k[bi];
        s_tlast  = bt_l[bi];
      end else begin
        s_tvalid = 1'b0;
        if (bi == gap_at) gap++;
      end
      m_tready = (rmode == 0) || (cyc % 2 == 0);
      #1;
      if (stall) begin
        chk("stall_vld", 32'(m_tvalid), 1);
        chk("stall_dat", 32'(m_tdata), 32'(pdat));
      end
      if (m_tvalid && pid_cyc < 0) pid_cyc = cyc;
      if (m_tvalid && m_tready && nout < 600) begin
        obuf[nout]  = m_tdata;
        olast[nout] = m_tlast;
        nout++;
        last_cyc = cyc;
      end
      stall = m_tvalid && !m_tready;
      pdat  = m_tdata;
      if (s_tvalid && s_tready) bi++;
      @(posedge clock); #1;
    end
    s_tvalid = 1'b0;
  endtask

  task automatic check_pkt(input string tag);
    chk({tag, "_timeout"}, 32'(timeout), 0);
    chk({tag, "_len"}, nout, n_exp);
    chk({tag, "_pid_lat"}, pid_cyc, 1);
    for (int i = 0; i < n_exp; i++) begin
      chk({tag, "_byte"}, 32'(obuf[i]), 32'(exp_d[i]));
      chk({tag, "_tlast"}, 32'(olast[i]), (i == n_exp - 1) ? 1 : 0);
    end
  endtask

  initial begin
    reset = 1'b1; parity_i = 1'b0; s_tvalid = 1'b0; s_tkeep = 1'b0;
    s_tlast = 1'b0; s_tdata = 8'h00; m_tready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_m_tvalid", 32'(m_tvalid), 0);
    chk("rst_m_tlast", 32'(m_tlast), 0);
    chk("rst_m_tdata", 32'(m_tdata), 'h00);
    chk("rst_s_tready", 32'(s_tready), 0);
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_sent", 32'(sent_o), 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // Zero-data packet, DATA0
    clr();
    beat(8'h00, 1'b0, 1'b1);
    expb(8'hC3); expb(8'h00); expb(8'h00);
    run_pkt(1'b0, 0, -1, -1);
    check_pkt("zdp0");
    @(posedge clock); #1;
    chk("zdp0_sent_once", 32'(sent_o), 0);
    chk("zdp0_idle_busy", 32'(busy_o), 0);

    // "123456789" at full rate, DATA1
    load_std(1'b1);
    run_pkt(1'b1, 0, -1, -1);
    check_pkt("std_full");
    chk("std_full_back2back", last_cyc - pid_cyc, n_exp - 1);

    // Same packet with a toggling sink
    load_std(1'b1);
    run_pkt(1'b1, 1, -1, -1);
    check_pkt("std_toggle");

    // 512 zero bytes (DATA1) then an immediate ZDP (DATA0)
    clr();
    expb(8'h4B);
    for (int i = 0; i < 512; i++) begin
      beat(8'h00, 1'b1, i == 511);
      expb(8'h00);
    end
    crc_ref = sw_crc(1, 512);
    expb(crc_ref[7:0]);
    expb(crc_ref[15:8]);
    run_pkt(1'b1, 0, -1, -1);
    check_pkt("zero512");
    clr();
    beat(8'h00, 1'b0, 1'b1);
    expb(8'hC3); expb(8'h00); expb(8'h00);
    run_pkt(1'b0, 0, -1, -1);
    check_pkt("zdp_b2b");

    // Reset after PID plus 5 of 20 payload bytes
    clr();
    for (int i = 0; i < 20; i++) beat(8'(8'h50 + i), 1'b1, i == 19);
    run_pkt(1'b1, 0, -1, 6);
    chk("abort_count", nout, 6);
    chk("abort_byte5", 32'(obuf[5]), 'h54);
    reset = 1'b1;
    s_tvalid = 1'b0;
    @(posedge clock); #1;
    chk("abort_m_tvalid", 32'(m_tvalid), 0);
    chk("abort_m_tlast", 32'(m_tlast), 0);
    chk("abort_m_tdata", 32'(m_tdata), 'h00);
    chk("abort_busy", 32'(busy_o), 0);
    chk("abort_sent", 32'(sent_o), 0);
    chk("abort_s_tready", 32'(s_tready), 0);
    reset = 1'b0;
    @(posedge clock); #1;
    load_std(1'b0);
    run_pkt(1'b0, 0, -1, -1);
    check_pkt("after_abort");

    // Leading empty beat, 3-cycle upstream gap, trailing empty last beat
    clr();
    beat(8'h00, 1'b0, 1'b0);
    expb(8'h4B);
    for (int i = 0; i < 9; i++) begin
      beat(8'(8'h31 + i), 1'b1, 1'b0);
      expb(8'(8'h31 + i));
    end
    beat(8'h00, 1'b0, 1'b1);
    expb(8'hC8);
    expb(8'hB4);
    run_pkt(1'b1, 0, 5, -1);
    check_pkt("gaps");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
